dcache_dm: RTL



---
 rtl/dcache_dm_pkg.sv | 27 ++
 rtl/dcache_dm_array.sv | 47 ++++
 rtl/dcache_dm.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/dcache_dm_pkg.sv
// Shared types for the data cache: execute-stage uop encoding, cache FSM states
// and the saturating increment used by the DCACHE_STATS_EN counters.
package dcache_dm_pkg;

    typedef enum logic [2:0] {
        NOP = 3'd0,
        ALU = 3'd1,
        LDR = 3'd2,
        STR = 3'd3,
        BR  = 3'd4
    } Uop;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_MEM  = 2'd2
    } DCacheState;

    function automatic logic is_mem_uop(input Uop u);
        return (u == LDR) || (u == STR);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/dcache_dm_array.sv
// Tag/data/valid storage for the direct-mapped cache: one synchronous write port,
// combinational read, valid bits cleared asynchronously by reset_n.
module dcache_dm_array #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 11,
    parameter int LINES  = 32,
    parameter int IDX_W  = $clog2(LINES)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [TAG_W-1:0]  wtag,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  ridx,
    output logic [TAG_W-1:0]  rtag,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid
);

    logic [LINES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];

    always_comb begin
        valid_d = valid_q;
        if (we) valid_d[widx] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) valid_q <= '0;
        else          valid_q <= valid_d;
    end

    // Tag and data contents are meaningless until the valid bit is set, so no reset.
    always_ff @(posedge clock) begin
        if (we) begin
            tag_q[widx]  <= wtag;
            data_q[widx] <= wdata;
        end
    end

    assign rtag   = tag_q[ridx];
    assign rdata  = data_q[ridx];
    assign rvalid = valid_q[ridx];

endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache with a req/ack backing port.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module dcache_dm
    import dcache_dm_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int LINES  = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  Uop                uop,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              req_valid,
    output logic              req_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              resp_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W;

    DCacheState        state_q, state_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] fill_q, fill_d;

    logic [IDX_W-1:0]  req_idx, arr_idx;
    logic [TAG_W-1:0]  req_tag, arr_tag, rd_tag;
    logic [DATA_W-1:0] arr_wdata, rd_data;
    logic              arr_we, rd_valid, hit, accept;

    assign req_idx = addr[IDX_W-1:0];
    assign req_tag = addr[ADDR_W-1:IDX_W];
    assign hit     = rd_valid && (rd_tag == req_tag);
    assign accept  = req_valid && (state_q == IDLE) && is_mem_uop(uop);

    dcache_dm_array #(
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W),
        .LINES  (LINES),
        .IDX_W  (IDX_W)
    ) u_array (
        .clock   (clock),
        .reset_n (reset_n),
        .we      (arr_we),
        .widx    (arr_idx),
        .wtag    (arr_tag),
        .wdata   (arr_wdata),
        .ridx    (req_idx),
        .rtag    (rd_tag),
        .rdata   (rd_data),
        .rvalid  (rd_valid)
    );

    // In RD_MISS/WR_MEM, mem_req_q low means the ack has been taken and the response is due.
    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        data_out_d   = '0;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        fill_d       = fill_q;
        arr_we       = 1'b0;
        arr_idx      = req_idx;
        arr_tag      = req_tag;
        arr_wdata    = data_in;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (uop == LDR) begin
                        if (hit) begin
                            resp_valid_d = 1'b1;
                            data_out_d   = rd_data;
                        end else begin
                            state_d    = RD_MISS;
                            mem_req_d  = 1'b1;
                            mem_we_d   = 1'b0;
                            mem_addr_d = addr;
                        end
                    end else begin
                        state_d     = WR_MEM;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = addr;
                        mem_wdata_d = data_in;
                        arr_we      = hit;
                    end
                end
            end
            RD_MISS: begin
                if (mem_req_q) begin
                    if (mem_ack) begin
                        mem_req_d = 1'b0;
                        fill_d    = mem_rdata;
                        arr_we    = 1'b1;
                        arr_idx   = mem_addr_q[IDX_W-1:0];
                        arr_tag   = mem_addr_q[ADDR_W-1:IDX_W];
                        arr_wdata = mem_rdata;
                    end
                end else begin
                    resp_valid_d = 1'b1;
                    data_out_d   = fill_q;
                    state_d      = IDLE;
                end
            end
            WR_MEM: begin
                if (mem_req_q) begin
                    if (mem_ack) mem_req_d = 1'b0;
                end else begin
                    resp_valid_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            data_out_q   <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            data_out_q   <= data_out_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    always_ff @(posedge clock) begin
        fill_q <= fill_d;
    end

    // Gated by reset_n so nothing is accepted while reset is held.
    assign req_ready  = reset_n && (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign data_out   = data_out_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (accept) begin
            if (hit) hit_count_d  = sat_inc(hit_count_q);
            else     miss_count_d = sat_inc(miss_count_q);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule
